// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encodings, register constants and stage-control words
package pipeline_ctrl_pkg;
  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] MWAIT = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] DEF_EXIT_CODE = 32'd10;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_rst;
    logic idex_rst;
    logic exmem_rst;
    logic memwb_rst;
  } ctl_t;
  localparam ctl_t CTL_RESET = 9'b1_1111_1111;
  localparam ctl_t CTL_NORMAL = 9'b1_1111_0000;
  localparam ctl_t CTL_FREEZE = 9'b0_0000_0000;
  localparam ctl_t CTL_STALL = 9'b0_0111_0100;
  localparam ctl_t CTL_FLUSH = 9'b1_1111_1100;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs, stage-register controls and counters of the pipeline sequencer
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic go;
  logic [4:0] id_rs1, id_rs2;
  logic id_rs1_used, id_rs2_used;
  logic ex_MemRead, ex_RegWrite;
  logic [4:0] ex_WriteRegNo;
  logic ex_branch_taken, mem_req, wb_ecall;
  logic [31:0] wb_a7;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_rst, idex_rst, exmem_rst, memwb_rst;
  logic halted;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  modport master(
    output go, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_MemRead, ex_RegWrite,
           ex_WriteRegNo, ex_branch_taken, mem_req, wb_ecall, wb_a7,
    input pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_rst, idex_rst, exmem_rst,
          memwb_rst, halted, cycle_cnt, stall_cnt, flush_cnt
  );
  modport slave(
    input go, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_MemRead, ex_RegWrite,
          ex_WriteRegNo, ex_branch_taken, mem_req, wb_ecall, wb_a7,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_rst, idex_rst, exmem_rst,
           memwb_rst, halted, cycle_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage read of a register a load in EX has not produced yet
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_MemRead,
  input  logic       ex_RegWrite,
  input  logic [4:0] ex_WriteRegNo,
  output logic       load_use
);
  assign load_use = ex_MemRead & ex_RegWrite & (ex_WriteRegNo != REG_ZERO) &
                    ((id_rs1_used & (id_rs1 == ex_WriteRegNo)) | (id_rs2_used & (id_rs2 == ex_WriteRegNo)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequences stage-register enables/clears for stalls, flushes, memory waits and exit halt
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          MEM_LAT   = 2,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] EXIT_CODE = DEF_EXIT_CODE
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave bus
);
  localparam int WW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  logic [1:0] state, state_nxt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic halted, load_use, exit_hit, mem_hold, wait_busy, freeze, stall_ev, flush_ev;
  ctl_t ctl;
  load_use_detect u_lud (
    .id_rs1(bus.id_rs1),
    .id_rs2(bus.id_rs2),
    .id_rs1_used(bus.id_rs1_used),
    .id_rs2_used(bus.id_rs2_used),
    .ex_MemRead(bus.ex_MemRead),
    .ex_RegWrite(bus.ex_RegWrite),
    .ex_WriteRegNo(bus.ex_WriteRegNo),
    .load_use(load_use)
  );
  assign exit_hit = (state == RUN) & bus.wb_ecall & (bus.wb_a7 == EXIT_CODE);
  assign mem_hold = (state == RUN) & ~exit_hit & bus.mem_req & (MEM_LAT > 0);
  assign wait_busy = (state == MWAIT) & (wcnt != '0);
  assign freeze = (state == HALT) | wait_busy | mem_hold;
  assign stall_ev = freeze ? (state != HALT) : ~bus.ex_branch_taken & load_use;
  assign flush_ev = ~freeze & bus.ex_branch_taken;
  always_comb begin
    ctl = rst ? CTL_RESET : freeze ? CTL_FREEZE : bus.ex_branch_taken ? CTL_FLUSH : load_use ? CTL_STALL : CTL_NORMAL;
    state_nxt = state == HALT ? (bus.go ? RUN : HALT) : exit_hit ? HALT : (mem_hold | wait_busy) ? MWAIT : RUN;
    wcnt_nxt = mem_hold ? WW'(MEM_LAT - 1) : wait_busy ? wcnt - WW'(1) : wcnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wcnt <= '0;
      halted <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt <= wcnt_nxt;
      halted <= state_nxt == HALT;
      if (state != HALT && ~&cycle_cnt) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_ev && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
          bus.ifid_rst, bus.idex_rst, bus.exmem_rst, bus.memwb_rst} = ctl;
  assign bus.halted = halted;
  assign bus.cycle_cnt = cycle_cnt;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule
